// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer between a multi-nibble fetch port
// and a single-nibble data port sharing one narrow RAM.
module ram_arbiter #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned FETCH_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          f_req,
    input  logic [ADDR_W-1:0]             f_addr,
    output logic                          f_ack,
    output logic [DATA_W*FETCH_BEATS-1:0] f_data,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          d_ack,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          busy,
    output logic                          ram_we,
    output logic                          ram_re,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_din,
    input  logic [DATA_W-1:0]             ram_dout
);

    localparam int unsigned F_W    = DATA_W * FETCH_BEATS;
    localparam int unsigned BEAT_W = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_RESP_F,
        S_RESP_D
    } state_t;

    state_t              r_state;
    logic                r_last_data;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_f_ack;
    logic [F_W-1:0]      r_f_data;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_busy;
    logic                r_ram_we;
    logic                r_ram_re;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_din;
    logic                w_grant_f;

    // Fetch wins when alone or when data was served last.
    assign w_grant_f = f_req & (~d_req | r_last_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_data <= 1'b1;
            r_beat      <= '0;
            r_f_ack     <= 1'b0;
            r_f_data    <= '0;
            r_d_ack     <= 1'b0;
            r_d_rdata   <= '0;
            r_busy      <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
        end else begin
            r_f_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The RAM strobe registers double as the latched request.
                    if (w_grant_f) begin
                        r_state     <= S_FETCH;
                        r_last_data <= 1'b0;
                        r_beat      <= '0;
                        r_busy      <= 1'b1;
                        r_ram_re    <= 1'b1;
                        r_ram_addr  <= f_addr;
                    end else if (d_req) begin
                        r_state     <= S_DATA;
                        r_last_data <= 1'b1;
                        r_busy      <= 1'b1;
                        r_ram_we    <= d_we;
                        r_ram_re    <= ~d_we;
                        r_ram_addr  <= d_addr;
                        r_ram_din   <= d_wdata;
                    end
                end
                S_FETCH: begin
                    // Shift left so beat 0 ends up in the top nibble.
                    r_f_data <= F_W'({r_f_data, ram_dout});
                    if (r_beat == LAST_BEAT) begin
                        r_state    <= S_RESP_F;
                        r_f_ack    <= 1'b1;
                        r_ram_re   <= 1'b0;
                        r_ram_addr <= '0;
                    end else begin
                        r_beat     <= r_beat + BEAT_W'(1);
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                    end
                end
                S_DATA: begin
                    if (!r_ram_we) begin
                        r_d_rdata <= ram_dout;
                    end
                    r_state    <= S_RESP_D;
                    r_d_ack    <= 1'b1;
                    r_ram_we   <= 1'b0;
                    r_ram_re   <= 1'b0;
                    r_ram_addr <= '0;
                    r_ram_din  <= '0;
                end
                S_RESP_F, S_RESP_D: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign f_ack    = r_f_ack;
    assign f_data   = r_f_data;
    assign d_ack    = r_d_ack;
    assign d_rdata  = r_d_rdata;
    assign busy     = r_busy;
    assign ram_we   = r_ram_we;
    assign ram_re   = r_ram_re;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [11:0] f_addr;
    logic        f_ack;
    logic [15:0] f_data;
    logic        d_req;
    logic        d_we;
    logic [11:0] d_addr;
    logic [3:0]  d_wdata;
    logic        d_ack;
    logic [3:0]  d_rdata;
    logic        busy;
    logic        ram_we;
    logic        ram_re;
    logic [11:0] ram_addr;
    logic [3:0]  ram_din;
    logic [3:0]  ram_dout;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side RAM (the environment) and the model's view of its contents.
    logic [3:0] mem    [4096];
    logic [3:0] shadow [4096];
    assign ram_dout = ram_re ? mem[ram_addr] : 4'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: one outstanding transaction described by its grant cycle.
    int          m_gcyc, m_ack, m_free;
    bit          m_kind_f, m_last_data;
    logic [11:0] m_addr;
    logic        m_we;
    logic [3:0]  m_wdata, m_dexp;
    logic [15:0] m_fexp;

    typedef struct {
        bit          is_f;
        logic        we;
        logic [11:0] addr;
        logic [3:0]  wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [3:0] v);
        mem[a]    = v;
        shadow[a] = v;
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 12'($urandom_range(0, 15));
        return 12'($urandom_range(4088, 4095));
    endfunction

    // Advance one clock; the RAM commits a write seen during the ending cycle.
    task automatic tick();
        logic        we_c;
        logic [11:0] a_c;
        logic [3:0]  d_c;
        we_c = ram_we;
        a_c  = ram_addr;
        d_c  = ram_din;
        @(posedge clk);
        #1;
        if (we_c) mem[a_c] = d_c;
        cyc++;
    endtask

    task automatic model_consume();
        if (cyc >= m_free) begin
            if (f_req && (!d_req || m_last_data)) begin
                m_kind_f    = 1'b1;
                m_gcyc      = cyc;
                m_addr      = f_addr;
                m_fexp      = '0;
                for (int b = 0; b < 4; b++)
                    m_fexp = {m_fexp[11:0], shadow[12'(int'(f_addr) + b)]};
                m_ack       = cyc + 5;
                m_free      = cyc + 6;
                m_last_data = 1'b0;
            end else if (d_req) begin
                m_kind_f    = 1'b0;
                m_gcyc      = cyc;
                m_addr      = d_addr;
                m_we        = d_we;
                m_wdata     = d_wdata;
                if (d_we) shadow[d_addr] = d_wdata;
                else      m_dexp = shadow[d_addr];
                m_ack       = cyc + 2;
                m_free      = cyc + 3;
                m_last_data = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        int          off;
        logic        e_we, e_re;
        logic [11:0] e_addr;
        logic [3:0]  e_din;
        bit          e_fack, e_dack;
        off    = cyc - m_gcyc;
        e_we   = 1'b0;
        e_re   = 1'b0;
        e_addr = '0;
        e_din  = '0;
        if (m_kind_f && off >= 1 && off <= 4) begin
            e_re   = 1'b1;
            e_addr = 12'(int'(m_addr) + off - 1);
        end else if (!m_kind_f && off == 1) begin
            e_we   = m_we;
            e_re   = ~m_we;
            e_addr = m_addr;
            e_din  = m_wdata;
        end
        e_fack = m_kind_f && (cyc == m_ack);
        e_dack = !m_kind_f && (cyc == m_ack);
        chk("f_ack", 64'(f_ack), 64'(e_fack));
        chk("d_ack", 64'(d_ack), 64'(e_dack));
        chk("busy", 64'(busy), 64'((cyc > m_gcyc) && (cyc < m_free)));
        chk("ram_strobes", 64'({ram_we, ram_re, ram_addr, ram_din}),
            64'({e_we, e_re, e_addr, e_din}));
        if (e_fack) chk("f_data", 64'(f_data), 64'(m_fexp));
        if (e_dack && !m_we) chk("d_rdata", 64'(d_rdata), 64'(m_dexp));
    endtask

    task automatic step();
        model_consume();
        tick();
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 1'b0;
        d_req = 1'b0;
        tick();
        rst_n       = 1'b1;
        cyc         = 0;
        m_gcyc      = -100;
        m_ack       = -1;
        m_free      = 0;
        m_kind_f    = 1'b0;
        m_last_data = 1'b1;
        chk("reset_outputs",
            64'({f_ack, f_data, d_ack, d_rdata, busy, ram_we, ram_re, ram_addr, ram_din}), 64'(0));
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int lat;
        bit got;
        if (v.is_f) begin
            f_req  = 1'b1;
            f_addr = v.addr;
        end else begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            step();
            lat++;
            got = v.is_f ? f_ack : d_ack;
        end
        chk($sformatf("vec%0d_ack", idx), 64'(got), 64'(1));
        chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.is_f ? 5 : 2));
        if (v.is_f)
            chk($sformatf("vec%0d_f_data", idx), 64'(f_data), 64'(v.exp));
        else if (!v.we)
            chk($sformatf("vec%0d_d_rdata", idx), 64'(d_rdata), 64'(v.exp[3:0]));
        f_req = 1'b0;
        d_req = 1'b0;
        step();
    endtask

    initial begin
        bit order [$];
        bit got, f_prev, d_prev;
        int n;

        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 4'($urandom);
            shadow[i] = mem[i];
        end
        preload(12'h010, 4'hA); preload(12'h011, 4'hB);
        preload(12'h012, 4'hC); preload(12'h013, 4'hD);
        preload(12'hFFE, 4'h1); preload(12'hFFF, 4'h2);
        preload(12'h000, 4'h3); preload(12'h001, 4'h4);
        preload(12'h456, 4'h3);

        vecs[0] = '{1'b1, 1'b0, 12'h010, 4'h0, 16'hABCD};
        vecs[1] = '{1'b0, 1'b1, 12'h123, 4'h7, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 12'h123, 4'h0, 16'h0007};
        vecs[3] = '{1'b1, 1'b0, 12'hFFE, 4'h0, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 12'hFFF, 4'h0, 16'h0002};
        vecs[5] = '{1'b0, 1'b1, 12'h000, 4'hF, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 12'h000, 4'h0, 16'h000F};
        vecs[7] = '{1'b1, 1'b0, 12'hFFE, 4'h0, 16'h12F4};

        do_reset();
        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Address and data changed after grant must not affect the write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h200; d_wdata = 4'h9;
        step();
        d_addr = 12'h456; d_wdata = 4'hE;
        step();
        chk("late_change_ack", 64'(d_ack), 64'(1));
        d_req = 1'b0;
        step();
        chk("late_change_target", 64'(mem[12'h200]), 64'(4'h9));
        chk("late_change_other", 64'(mem[12'h456]), 64'(4'h3));

        // Both requests held from reset alternate, fetch first.
        do_reset();
        f_req = 1'b1; f_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h123;
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            step();
            if (f_ack) order.push_back(1'b1);
            if (d_ack) order.push_back(1'b0);
        end
        chk("rr_ack_count", 64'(order.size()), 64'(4));
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'((k % 2) == 0));
        f_req = 1'b0; d_req = 1'b0;
        step(); step();

        // Reset during fetch beat 2 discards the fetch and last_grant.
        do_reset();
        f_req = 1'b1; f_addr = 12'h010;
        step(); step(); step();
        do_reset();
        chk("mid_reset_no_ack", 64'(f_ack), 64'(0));
        f_req = 1'b1; f_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h123;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            step(); n++;
            got = f_ack | d_ack;
        end
        chk("post_reset_first_grant", 64'({f_ack, d_ack}), 64'(2'b10));
        chk("post_reset_f_data", 64'(f_data), 64'(16'hABCD));
        f_req = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            step(); n++;
            got = d_ack;
        end
        chk("post_reset_d_ack", 64'(got), 64'(1));
        chk("post_reset_d_rdata", 64'(d_rdata), 64'(4'h7));
        d_req = 1'b0;
        step();

        // Randomized traffic; each agent holds its request until acked.
        do_reset();
        f_prev = 1'b0; d_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (f_prev || !f_req) begin
                f_req = ($urandom_range(0, 2) == 0);
                f_addr = rand_addr();
            end
            if (d_prev || !d_req) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = 1'($urandom);
                d_addr  = rand_addr();
                d_wdata = 4'($urandom);
            end
            f_prev = f_ack;
            d_prev = d_ack;
            step();
        end
        f_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 10; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
